// File: rtl/alu_seq_6502.sv
// ---------------------------------------------------------------------------
// alu_seq_6502 -- multi-byte arithmetic sequencer for a shared alu_6502.
//
// Runs 1..MAX_LEN byte ADD/SUB/ROL/ROR/OR/AND/XOR/PASS operations one byte
// at a time through an external alu_6502. Carry is chained between bytes;
// BCD add results are decimal-adjusted here from the ALU's hc/co outputs.
// ROR walks the operand MSB byte first, every other op LSB byte first.
//
// Handshakes: every channel uses strict valid/ready. A transfer happens on
// the rising clk edge where valid and ready are both high. The producer holds
// valid and its data stable until that edge. The ready side may change at
// any time and never depends combinationally on valid.
//
// Ports
//   clk, reset_n               clock, asynchronous active-low reset
//   cmd_valid/cmd_ready        command channel (ready only while idle)
//   cmd_op, cmd_len            operation select, byte count minus one
//   cmd_ci, cmd_bcd            initial carry, decimal mode (ADD only)
//   in_valid/in_ready          operand byte pair channel
//   in_a, in_b                 operand bytes (in_b unused by ROL/ROR/PASS)
//   out_valid/out_ready        result byte channel
//   out_data                   result byte
//   done                       one-cycle pulse after the last result byte
//   flag_c/z/n/v               final flags, valid from done until next cmd
//   alu_op/ai/bi/ci/bcd/right  drive the ALU inputs (only while executing)
//   alu_rdy                    ALU register enable, high for one cycle/byte
//   alu_out/co/v/hc            registered ALU results
// ---------------------------------------------------------------------------
module alu_seq_6502 #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_ci,
  input  logic             cmd_bcd,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             done,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v,
  output logic [3:0]       alu_op,
  output logic [7:0]       alu_ai,
  output logic [7:0]       alu_bi,
  output logic             alu_ci,
  output logic             alu_bcd,
  output logic             alu_right,
  output logic             alu_rdy,
  input  logic [7:0]       alu_out,
  input  logic             alu_co,
  input  logic             alu_v,
  input  logic             alu_hc
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_ROL  = 3'b010;
  localparam logic [2:0] OP_ROR  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  // Highest byte index; the counter saturates here so it can never wrap.
  localparam logic [LEN_W-1:0] CNT_LAST = LEN_W'(MAX_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT_IN = 3'd1,
    S_EXEC    = 3'd2,
    S_CAPT    = 3'd3,
    S_EMIT    = 3'd4,
    S_FIN     = 3'd5
  } state_t;

  state_t state, state_nx;

  logic [2:0]       op_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;
  logic             bcd_q;
  logic             carry_q;
  logic             zacc_q;
  logic             n_q;
  logic             v_q;
  logic [7:0]       a_q;
  logic [7:0]       b_q;
  logic [7:0]       out_q;
  logic [7:0]       res_adj;
  logic             last_byte;

  assign last_byte = (cnt_q == len_q);
  assign out_data  = out_q;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_nx  = state;
    cmd_ready = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    alu_rdy   = 1'b0;
    alu_op    = 4'b0000;
    alu_ai    = 8'h00;
    alu_bi    = 8'h00;
    alu_ci    = 1'b0;
    alu_bcd   = 1'b0;
    alu_right = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nx = S_WAIT_IN;
      end
      S_WAIT_IN: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = S_EXEC;
      end
      S_EXEC: begin
        // ALU registers its result on the edge that ends this cycle.
        alu_rdy = 1'b1;
        alu_ai  = a_q;
        alu_bi  = b_q;
        alu_ci  = carry_q;
        alu_bcd = bcd_q;
        case (op_q)
          OP_ADD:  alu_op = 4'b0011;
          OP_SUB:  alu_op = 4'b0111;
          OP_ROL:  alu_op = 4'b1011;
          OP_ROR: begin
            alu_op    = 4'b1111;
            alu_right = 1'b1;
          end
          OP_OR:   alu_op = 4'b1100;
          OP_AND:  alu_op = 4'b1101;
          OP_XOR:  alu_op = 4'b1110;
          OP_PASS: alu_op = 4'b1111;
          default: alu_op = 4'b1111;
        endcase
        state_nx = S_CAPT;
      end
      S_CAPT: state_nx = S_EMIT;
      S_EMIT: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = last_byte ? S_FIN : S_WAIT_IN;
      end
      S_FIN: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Decimal adjust: the ALU flags a decimal digit overflow through hc/co
  // but leaves the raw nibble sums in alu_out, so each flagged nibble gets +6.
  always_comb begin
    res_adj = alu_out;
    if (bcd_q) begin
      if (alu_hc) res_adj[3:0] = alu_out[3:0] + 4'd6;
      if (alu_co) res_adj[7:4] = alu_out[7:4] + 4'd6;
    end
  end

  // Command, operand and result datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q    <= 3'b000;
      len_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= 1'b0;
      carry_q <= 1'b0;
      zacc_q  <= 1'b0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      out_q   <= 8'h00;
      flag_c  <= 1'b0;
      flag_z  <= 1'b0;
      flag_n  <= 1'b0;
      flag_v  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q    <= cmd_op;
            len_q   <= cmd_len;
            cnt_q   <= '0;
            bcd_q   <= cmd_bcd & (cmd_op == OP_ADD);
            carry_q <= cmd_ci;
            zacc_q  <= 1'b1;
            flag_c  <= 1'b0;
            flag_z  <= 1'b0;
            flag_n  <= 1'b0;
            flag_v  <= 1'b0;
          end
        end
        S_WAIT_IN: begin
          if (in_valid) begin
            a_q <= in_a;
            b_q <= in_b;
          end
        end
        S_CAPT: begin
          // op_q[2]==0 selects the carry-chaining ops (ADD/SUB/ROL/ROR).
          carry_q <= op_q[2] ? 1'b0 : alu_co;
          zacc_q  <= zacc_q & (res_adj == 8'h00);
          out_q   <= res_adj;
          n_q     <= res_adj[7];
          v_q     <= alu_v;
        end
        S_EMIT: begin
          if (out_ready) begin
            if (last_byte) begin
              flag_c <= carry_q;
              flag_z <= zacc_q;
              flag_n <= n_q;
              flag_v <= v_q;
            end else if (cnt_q != CNT_LAST) begin
              cnt_q <= cnt_q + LEN_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_6502.sv
// ---------------------------------------------------------------------------
// tb_alu_seq_6502 -- self-checking bench for alu_seq_6502.
//
// An alu_6502 stand-in registers ALU results on alu_rdy. A value-level model
// computes the whole multi-byte result and final flags from the operation
// rules; a negedge monitor checks every result byte and every done pulse
// against queues filled from that model.
// ---------------------------------------------------------------------------
module tb_alu_seq_6502;

  localparam int LEN_W = 3;
  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_ROL  = 3'd2;
  localparam logic [2:0] OP_ROR  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_AND  = 3'd5;
  localparam logic [2:0] OP_XOR  = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             cmd_valid, cmd_ready, cmd_ci, cmd_bcd;
  logic [2:0]       cmd_op;
  logic [LEN_W-1:0] cmd_len;
  logic             in_valid, in_ready;
  logic [7:0]       in_a, in_b;
  logic             out_valid, out_ready;
  logic [7:0]       out_data;
  logic             done, flag_c, flag_z, flag_n, flag_v;
  logic [3:0]       alu_op;
  logic [7:0]       alu_ai, alu_bi, alu_out;
  logic             alu_ci, alu_bcd, alu_right, alu_rdy;
  logic             alu_co, alu_v, alu_hc;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [4:0] expf_q[$];   // {v_checked, c, z, n, v}
  logic mon_en = 1'b0;
  logic gap_en = 1'b0;
  logic out_mode = 1'b0;   // 0: man_ready drives out_ready, 1: random
  logic man_ready = 1'b1;
  logic rnd_ready = 1'b1;
  logic bp_done;

  assign out_ready = out_mode ? rnd_ready : man_ready;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  alu_seq_6502 #(.MAX_LEN(8), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_len(cmd_len), .cmd_ci(cmd_ci), .cmd_bcd(cmd_bcd),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .done(done), .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n),
    .flag_v(flag_v),
    .alu_op(alu_op), .alu_ai(alu_ai), .alu_bi(alu_bi), .alu_ci(alu_ci),
    .alu_bcd(alu_bcd), .alu_right(alu_right), .alu_rdy(alu_rdy),
    .alu_out(alu_out), .alu_co(alu_co), .alu_v(alu_v), .alu_hc(alu_hc)
  );

  // ---------------- alu_6502 stand-in ----------------
  logic [8:0] s_lg;
  logic [7:0] s_tb, s_out;
  logic [4:0] s_l, s_h;
  logic       s_cin, s_hc, s_co, s_v;

  always_comb begin
    s_lg = 9'd0;
    s_tb = 8'd0;
    case (alu_op[1:0])
      2'b00: s_lg = {1'b0, alu_ai | alu_bi};
      2'b01: s_lg = {1'b0, alu_ai & alu_bi};
      2'b10: s_lg = {1'b0, alu_ai ^ alu_bi};
      default: s_lg = {1'b0, alu_ai};
    endcase
    if (alu_right) s_lg = {alu_ai[0], alu_ci, alu_ai[7:1]};
    case (alu_op[3:2])
      2'b00: s_tb = alu_bi;
      2'b01: s_tb = ~alu_bi;
      2'b10: s_tb = s_lg[7:0];
      default: s_tb = 8'h00;
    endcase
    s_cin = (alu_right || alu_op[3:2] == 2'b11) ? 1'b0 : alu_ci;
    s_l   = {1'b0, s_lg[3:0]} + {1'b0, s_tb[3:0]} + {4'd0, s_cin};
    s_hc  = s_l[4] | (alu_bcd & (s_l[3:1] >= 3'd5));
    s_h   = {1'b0, s_lg[7:4]} + {1'b0, s_tb[7:4]} + {4'd0, s_hc};
    s_co  = s_lg[8] | s_h[4] | (alu_bcd & (s_h[3:1] >= 3'd5));
    s_out = {s_h[3:0], s_l[3:0]};
    s_v   = (s_lg[7] == s_tb[7]) && (s_out[7] != s_lg[7]);
  end

  always @(posedge clk) begin
    if (alu_rdy) begin
      alu_out <= s_out;
      alu_co  <= s_co;
      alu_hc  <= s_hc;
      alu_v   <= s_v;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s @%0t", name, $time);
  endtask

  function automatic int bcd2int(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] int2bcd(input int s);
    return {4'(s / 10), 4'(s % 10)};
  endfunction

  // Value-level reference: av/bv are n-byte numbers (byte 0 least significant).
  task automatic model(input logic [2:0] op, input int n, input logic ci, input logic bcd,
                       input logic [63:0] av, input logic [63:0] bv,
                       output logic [63:0] rv, output logic c, output logic z,
                       output logic nf, output logic v, output logic vk);
    logic [63:0] mask, bx;
    logic [64:0] wide;
    int top, carry, s;
    top  = 8 * n - 1;
    mask = (n == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * n)) - 64'd1);
    av   = av & mask;
    bv   = bv & mask;
    rv   = 64'd0;
    c    = 1'b0;
    v    = 1'b0;
    vk   = 1'b1;
    case (op)
      OP_ADD, OP_SUB: begin
        if (op == OP_ADD && bcd) begin
          carry = int'(ci);
          for (int i = 0; i < n; i++) begin
            s = bcd2int(av[8*i +: 8]) + bcd2int(bv[8*i +: 8]) + carry;
            carry = (s >= 100) ? 1 : 0;
            if (carry == 1) s = s - 100;
            rv[8*i +: 8] = int2bcd(s);
          end
          c  = (carry == 1);
          vk = 1'b0;
        end else begin
          bx   = (op == OP_SUB) ? (~bv & mask) : bv;
          wide = {1'b0, av} + {1'b0, bx} + {64'd0, ci};
          rv   = wide[63:0] & mask;
          c    = wide[8 * n];
          v    = (av[top] == bx[top]) && (rv[top] != av[top]);
        end
      end
      OP_ROL: begin
        rv = {av[62:0], ci} & mask;
        c  = av[top];
        v  = av[top] ^ av[top - 1];
      end
      OP_ROR: begin
        rv = (av >> 1) | ({63'd0, ci} << top);
        c  = av[0];
      end
      OP_OR:   rv = av | bv;
      OP_AND:  rv = av & bv;
      OP_XOR:  rv = av ^ bv;
      default: rv = av;
    endcase
    z  = (rv == 64'd0);
    nf = (op == OP_ROR) ? rv[7] : rv[top];
  endtask

  // Pin the model itself against hand-computed results.
  task automatic pin(input string name, input logic [2:0] op, input int len, input logic ci,
                     input logic bcd, input logic [63:0] av, input logic [63:0] bv,
                     input logic [63:0] exp_rv, input logic [3:0] exp_czn_v);
    logic [63:0] rv;
    logic c, z, nf, v, vk;
    model(op, len + 1, ci, bcd, av, bv, rv, c, z, nf, v, vk);
    chk({name, "_model_r"}, rv, exp_rv);
    chk({name, "_model_f"}, {c, z, nf, vk & v}, {exp_czn_v[3:1], vk & exp_czn_v[0]});
  endtask

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic issue_cmd(input logic [2:0] op, input int len, input logic ci, input logic bcd);
    int t;
    cmd_op    = op;
    cmd_len   = LEN_W'(len);
    cmd_ci    = ci;
    cmd_bcd   = bcd;
    cmd_valid = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      t++;
      if (t > 200) begin
        fail_now("cmd_ready_timeout");
        break;
      end
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send_pair(input logic [7:0] a, input logic [7:0] b);
    int t, g;
    if (gap_en) begin
      g = $urandom_range(0, 2);
      repeat (g) begin
        @(posedge clk);
        #1;
      end
    end
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 200) begin
        fail_now("in_ready_timeout");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = $urandom_range(0, 255);
    in_b     = $urandom_range(0, 255);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    forever begin
      @(negedge clk);
      if (done) break;
      t++;
      if (t > 400) begin
        fail_now("done_timeout");
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_cmd(input logic [2:0] op, input int len, input logic ci, input logic bcd,
                         input logic [63:0] av, input logic [63:0] bv);
    logic [63:0] rv;
    logic c, z, nf, v, vk;
    int n, idx;
    n = len + 1;
    model(op, n, ci, bcd, av, bv, rv, c, z, nf, v, vk);
    for (int i = 0; i < n; i++) begin
      idx = (op == OP_ROR) ? (n - 1 - i) : i;
      exp_q.push_back(rv[8*idx +: 8]);
    end
    expf_q.push_back({vk, c, z, nf, v});
    issue_cmd(op, len, ci, bcd);
    for (int i = 0; i < n; i++) begin
      idx = (op == OP_ROR) ? (n - 1 - i) : i;
      send_pair(av[8*idx +: 8], bv[8*idx +: 8]);
    end
    wait_done();
  endtask

  // ---------------- random out_ready ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      rnd_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic       hold;
    logic [7:0] held;
    logic [4:0] f;
    hold = 1'b0;
    held = 8'h00;
    forever begin
      @(negedge clk);
      if (mon_en && reset_n) begin
        chk("in_out_excl", {31'd0, in_ready & out_valid}, 64'd0);
        if (alu_rdy) chk("alu_rdy_excl", {cmd_ready, in_ready, out_valid}, 64'd0);
        if (hold) chk("bp_stable", {out_valid, out_data}, {1'b1, held});
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) fail_now("unexpected_out_byte");
          else chk("out_data", out_data, exp_q.pop_front());
        end
        if (done) begin
          if (expf_q.size() == 0) fail_now("unexpected_done");
          else begin
            f = expf_q.pop_front();
            chk("flags_czn_v", {flag_c, flag_z, flag_n, f[4] & flag_v},
                {f[3], f[2], f[1], f[4] & f[0]});
          end
        end
        hold = out_valid & ~out_ready;
        held = out_data;
      end else begin
        hold = 1'b0;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0] av, bv;
    logic [2:0]  op;
    int          len, dcnt, t;
    logic        ci, bcd;

    cmd_valid = 1'b0; cmd_op = 3'd0; cmd_len = '0; cmd_ci = 1'b0; cmd_bcd = 1'b0;
    in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00;
    bp_done = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("reset_ctl", {cmd_ready, in_ready, out_valid, done, flag_c, flag_z, flag_n, flag_v,
                      alu_rdy, alu_bcd, alu_right, alu_ci}, 64'h800);
    chk("reset_bus", {out_data, alu_op, alu_ai, alu_bi}, 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", {cmd_ready, in_ready, out_valid}, 64'h4);
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Directed cases, model pinned to hand-computed values first
    pin("add2", OP_ADD, 1, 1'b0, 1'b0, 64'h00FF, 64'h0001, 64'h0100, 4'b0000);
    run_cmd(OP_ADD, 1, 1'b0, 1'b0, 64'h00FF, 64'h0001);
    pin("sub_a", OP_SUB, 0, 1'b1, 1'b0, 64'h50, 64'h70, 64'hE0, 4'b0010);
    run_cmd(OP_SUB, 0, 1'b1, 1'b0, 64'h50, 64'h70);
    pin("sub_b", OP_SUB, 0, 1'b1, 1'b0, 64'h70, 64'h70, 64'h00, 4'b1100);
    run_cmd(OP_SUB, 0, 1'b1, 1'b0, 64'h70, 64'h70);
    pin("bcd", OP_ADD, 0, 1'b0, 1'b1, 64'h99, 64'h01, 64'h00, 4'b1100);
    run_cmd(OP_ADD, 0, 1'b0, 1'b1, 64'h99, 64'h01);
    pin("ror", OP_ROR, 1, 1'b1, 1'b0, 64'h0102, 64'h0, 64'h8081, 4'b0010);
    run_cmd(OP_ROR, 1, 1'b1, 1'b0, 64'h0102, 64'h0);
    pin("rol", OP_ROL, 0, 1'b1, 1'b0, 64'h80, 64'h0, 64'h01, 4'b1001);
    run_cmd(OP_ROL, 0, 1'b1, 1'b0, 64'h80, 64'h0);
    pin("add8", OP_ADD, 7, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 4'b1100);
    run_cmd(OP_ADD, 7, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
    pin("and3", OP_AND, 2, 1'b1, 1'b0, 64'h0F0F0F, 64'hFF00FF, 64'h0F000F, 4'b0000);
    run_cmd(OP_AND, 2, 1'b1, 1'b0, 64'h0F0F0F, 64'hFF00FF);

    // Backpressure: hold out_ready low for 5 cycles on the first result byte
    man_ready = 1'b0;
    bp_done   = 1'b0;
    fork
      begin
        run_cmd(OP_ADD, 1, 1'b0, 1'b0, 64'h1234, 64'h1111);
        bp_done = 1'b1;
      end
    join_none
    t = 0;
    forever begin
      @(negedge clk);
      if (out_valid) break;
      t++;
      if (t > 100) begin
        fail_now("bp_out_valid_timeout");
        break;
      end
    end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk("bp_hold", {out_valid, in_ready, alu_rdy, out_data}, {1'b1, 1'b0, 1'b0, 8'h45});
    end
    @(posedge clk);
    #1;
    man_ready = 1'b1;
    t = 0;
    while (!bp_done && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!bp_done) fail_now("bp_cmd_timeout");

    // Reset during EXEC of byte 1 of a 4-byte ADD
    mon_en = 1'b0;
    issue_cmd(OP_ADD, 3, 1'b0, 1'b0);
    send_pair(8'h11, 8'h22);
    send_pair(8'h33, 8'h44);
    @(negedge clk);
    chk("exec_byte1", {31'd0, alu_rdy}, 64'd1);
    reset_n = 1'b0;
    #1;
    chk("abort_ctl", {cmd_ready, in_ready, out_valid, done, flag_c, flag_z, flag_n, flag_v,
                      alu_rdy, alu_bcd, alu_right, alu_ci}, 64'h800);
    chk("abort_bus", {out_data, alu_op, alu_ai, alu_bi}, 64'd0);
    dcnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("abort_no_done", dcnt, 64'd0);
    chk("abort_idle", {cmd_ready, in_ready, out_valid}, 64'h4);
    @(posedge clk);
    #1;
    exp_q.delete();
    expf_q.delete();
    mon_en = 1'b1;
    pin("xor", OP_XOR, 0, 1'b0, 1'b0, 64'hF0, 64'hFF, 64'h0F, 4'b0000);
    run_cmd(OP_XOR, 0, 1'b0, 1'b0, 64'hF0, 64'hFF);

    // Randomized commands with input gaps and random out_ready
    gap_en   = 1'b1;
    out_mode = 1'b1;
    for (int r = 0; r < 60; r++) begin
      op  = 3'($urandom_range(0, 7));
      len = $urandom_range(0, 7);
      ci  = 1'($urandom_range(0, 1));
      bcd = 1'($urandom_range(0, 1));
      av  = {$urandom, $urandom};
      bv  = {$urandom, $urandom};
      if (op == OP_ADD && bcd) begin
        for (int i = 0; i < 8; i++) begin
          av[8*i +: 8] = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
          bv[8*i +: 8] = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        end
      end
      run_cmd(op, len, ci, bcd, av, bv);
    end
    out_mode = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 64'd0);
    chk("expf_q_drained", expf_q.size(), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq_6502.md
Name: alu_seq_6502

Overview:
Multi-byte arithmetic sequencer that drives one shared alu_6502 instance, byte-serially, to execute 1..MAX_LEN byte add, subtract, rotate and logic operations. Operand bytes stream in and result bytes stream out over valid/ready handshakes. The sequencer chains carry between bytes and applies decimal adjust in BCD add mode. It sits between a requester (DMA/coprocessor glue) and the ALU, and owns the ALU's op/AI/BI/CI/BCD/right/RDY inputs.

Parameters:
MAX_LEN, 8, maximum operand length in bytes (power of 2)
LEN_W, 3, width of cmd_len, equal to log2(MAX_LEN)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  sequencer idle, command accepted when valid&ready
cmd_op  in  3  000 ADD, 001 SUB, 010 ROL, 011 ROR, 100 OR, 101 AND, 110 XOR, 111 PASS
cmd_len  in  LEN_W  byte count minus 1
cmd_ci  in  1  initial carry
cmd_bcd  in  1  decimal mode, honoured for ADD only
in_valid  in  1  operand byte pair offered
in_ready  out  1  operand pair accepted when valid&ready
in_a  in  8  operand A byte
in_b  in  8  operand B byte (ignored for ROL/ROR/PASS)
out_valid  out  1  result byte valid
out_ready  in  1  result consumer ready
out_data  out  8  result byte
done  out  1  one-cycle pulse after last result byte is taken
flag_c, flag_z, flag_n, flag_v  out  1 each  final flags, valid from done and held until next cmd accept
alu_op  out  4  to ALU op
alu_ai, alu_bi  out  8 each  to ALU AI/BI
alu_ci, alu_bcd, alu_right, alu_rdy  out  1 each  to ALU
alu_out  in  8  from ALU OUT
alu_co, alu_v, alu_hc  in  1 each  from ALU

Behaviour:
- Reset: state IDLE. cmd_ready=1. All other outputs 0, including flags and the carry register.
- Byte order: ROR is MSB first. All other ops are LSB first.
- States: IDLE -> (cmd_valid) latch cmd, carry=cmd_ci, zacc=1, cnt=0 -> WAIT_IN.
- WAIT_IN: in_ready=1. On in_valid, latch a and b -> EXEC.
- EXEC: alu_rdy=1 for exactly this cycle, so the ALU registers on this edge.
  - alu_ai=a, alu_bi=b, alu_ci=carry.
  - alu_op mapping: ADD 0011, SUB 0111 (ci=1 means no borrow), ROL 1011, ROR 1111 with alu_right=1, OR 1100, AND 1101, XOR 1110, PASS 1111.
  - alu_bcd = cmd_bcd & (op==ADD).
  - alu_right=0 for every op except ROR.
  - alu_rdy=0 in all other states; ALU inputs are don't-care there.
- CAPT: ALU outputs are valid here. Compute r = alu_out.
  - If bcd: add 6 to r[3:0] if alu_hc, and add 6 to r[7:4] if alu_co, each mod 16.
  - carry <= alu_co for ADD/SUB/ROL/ROR, 0 for logic ops and PASS.
  - zacc <= zacc & (r==0). out_data <= r. n <= r[7]. v <= alu_v.
  - Then -> EMIT.
- EMIT: out_valid=1, out_data stable until out_ready.
  - On out_ready, if cnt==cmd_len -> FIN. Otherwise cnt+1 -> WAIT_IN.
- FIN: done=1 for one cycle. flag_c=carry, flag_z=zacc, flag_n=n, flag_v=v. -> IDLE.
- Minimum throughput is 4 cycles/byte (WAIT_IN, EXEC, CAPT, EMIT) with in_valid and out_ready held high.
- in_ready and out_valid are never high in the same cycle.
- cmd_valid outside IDLE is ignored (cmd_ready=0).
- in_valid outside WAIT_IN is ignored.
- cmd_len=MAX_LEN-1 runs MAX_LEN bytes. The cnt compare must not wrap early.
- Reset asserted in any state aborts immediately to reset values. Partial results are discarded and done is not pulsed.

Test Plan:
- ADD, len=1 (2 bytes), ci=0, pairs (FF,01),(00,00) -> out 00 then 01, done, C=0 Z=0 N=0 V=0.
- SUB, len=0, ci=1, (50,70) -> out E0, C=0 N=1 Z=0 V=0. Then (70,70) -> out 00, C=1 Z=1.
- BCD ADD, len=0, ci=0, (99,01) -> ALU yields AA with hc=1, co=1 -> out 00, C=1 Z=1.
- ROR, len=1, ci=1, MSB first (01),(02) -> out 80 then 81, C=0. ROL, len=0, ci=1, (80) -> out 01, C=1.
- Backpressure: out_ready=0 for 5 cycles in EMIT -> out_valid=1 and out_data stable, in_ready=0, alu_rdy=0 throughout. Release -> one transfer, next byte proceeds.
- Reset mid-op: reset_n low during EXEC of byte 1 of a 4-byte ADD -> all outputs 0, no done. After release, cmd_ready=1 and a fresh 1-byte XOR (F0,FF) yields 0F.
